// File: rtl/irq_controller.sv
// irq_controller: edge-latched, masked, round-robin sharing of one core interrupt entry among N_SRC sources
module irq_controller #(
    parameter int          N_SRC      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_req,
    output logic             irq,
    output logic [31:0]      irq_addr,
    input  logic             irq_ack,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [31:0]      cfg_wd,
    output logic [31:0]      cfg_rd
);
    localparam int IW = $clog2(N_SRC);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t           state, state_n;
    logic [N_SRC-1:0] src_q, mask, pending, req, w1c, ack_clr, clr;
    logic [31:0]      vec [N_SRC];
    logic [IW-1:0]    grant_id, last_grant, choice;
    logic             ack_q, ack_evt, grant;
    int               d, best;

    assign ack_evt = irq_ack & ~ack_q;
    assign req     = pending & mask;
    assign w1c     = (cfg_we && cfg_addr == 4'd1) ? cfg_wd[N_SRC-1:0] : '0;
    assign ack_clr = (state == REQ && ack_evt) ? N_SRC'(1) << grant_id : '0;
    assign clr     = w1c | ack_clr;
    assign irq     = state == REQ;

    // round-robin pick: requesting source with the smallest distance past last_grant
    always_comb begin
        best   = N_SRC;
        d      = 0;
        choice = '0;
        for (int i = 0; i < N_SRC; i++) begin
            d = (i + N_SRC - 1 - int'(last_grant)) % N_SRC;
            if (req[i] && d < best) begin
                best   = d;
                choice = IW'(i);
            end
        end
    end

    // next-state: grant from IDLE, wait for ack edge in REQ, one quiet cycle in GAP
    always_comb begin
        state_n = state == IDLE ? (|req ? REQ : IDLE) :
                  state == REQ  ? (ack_evt ? GAP : REQ) : IDLE;
        grant   = state == IDLE && |req;
    end

    // state register and committed grant (vector captured at grant, held through REQ)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IW'(N_SRC - 1);
            irq_addr   <= '0;
        end else begin
            state <= state_n;
            if (grant) begin
                grant_id   <= choice;
                last_grant <= choice;
                irq_addr   <= vec[choice];
            end
        end
    end

    // request edge detect, pending latch, and config register writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q   <= '0;
            ack_q   <= 1'b0;
            pending <= '0;
            mask    <= '0;
            for (int i = 0; i < N_SRC; i++) vec[i] <= VEC_BASE + VEC_STRIDE * 32'(i);
        end else begin
            src_q   <= src_req;
            ack_q   <= irq_ack;
            pending <= (src_req & ~src_q) | (pending & ~clr);
            if (cfg_we && cfg_addr == 4'd0) mask <= cfg_wd[N_SRC-1:0];
            for (int i = 0; i < N_SRC; i++)
                if (cfg_we && int'(cfg_addr) == 4 + i) vec[i] <= cfg_wd;
        end
    end

    // zero-latency register readback; unmapped indices read 0
    always_comb begin
        cfg_rd = '0;
        if (cfg_addr == 4'd0) cfg_rd = 32'(mask);
        if (cfg_addr == 4'd1) cfg_rd = 32'(pending);
        if (cfg_addr == 4'd2) cfg_rd = {23'd0, state != IDLE, 5'd0, 3'(grant_id)};
        for (int i = 0; i < N_SRC; i++)
            if (int'(cfg_addr) == 4 + i) cfg_rd = vec[i];
    end
endmodule
